// File: rtl/tia_hsync_counter.sv
// -----------------------------------------------------------------------------
// tia_hsync_counter
//
// Horizontal timing front end of the TIA.
//   * Divides the colour clock by 4 into two non-overlapping strobes (s1, s2)
//     that clock the two-phase dynamic latches downstream.
//   * Runs the 6-bit polynomial (XNOR LFSR) horizontal counter. It advances
//     once per s2 strobe; 57 counts make one 228-colour-clock line.
//   * Decodes HSYNC, HBLANK and line-end from the counter. All decodes are
//     registered and change on the advance clock that enters the decoded index.
//
// Ports
//   clk        in   colour clock, all state updates on posedge
//   r          in   asynchronous reset, active-high
//   rsync      in   one-clk strobe, restarts the line (divider and counter to 0)
//   hmove_req  in   one-clk strobe, requests late hblank on the next line
//   s1         out  phase-1 strobe, high one clk out of every 4
//   s2         out  phase-2 strobe, high one clk out of every 4
//   hcount     out  raw polynomial counter state
//   hsync      out  horizontal sync
//   hblank     out  horizontal blank
//   line_end   out  one-clk pulse on the clk the counter wraps to 0
// -----------------------------------------------------------------------------
module tia_hsync_counter #(
   parameter int unsigned LINE_COUNTS = 57,  // counter states per line (<= 63)
   parameter int unsigned HS_SET      = 4,   // index where hsync asserts
   parameter int unsigned HS_CLR      = 8,   // index where hsync deasserts
   parameter int unsigned RHB_EARLY   = 16,  // index where hblank clears
   parameter int unsigned RHB_LATE    = 18   // same, after an hmove request
) (
   input  logic       clk,
   input  logic       r,
   input  logic       rsync,
   input  logic       hmove_req,
   output logic       s1,
   output logic       s2,
   output logic [5:0] hcount,
   output logic       hsync,
   output logic       hblank,
   output logic       line_end
);

   // One step of the counter polynomial: shift right, XNOR of the two low
   // bits feeds the top. The all-ones state is a lock-up state of an XNOR
   // LFSR and is never reached from 000000.
   function automatic logic [5:0] lfsr_next(input logic [5:0] h);
      return {~(h[1] ^ h[0]), h[5:1]};
   endfunction

   // Counter state reached after k advances from 000000. Used only at
   // elaboration to turn count indices into the raw states to decode.
   function automatic logic [5:0] lfsr_at(input int unsigned k);
      logic [5:0] h;
      h = 6'b000000;
      for (int unsigned i = 0; i < k; i++) begin
         h = lfsr_next(h);
      end
      return h;
   endfunction

   localparam logic [5:0] HC_LAST      = lfsr_at(LINE_COUNTS - 1);
   localparam logic [5:0] HC_HS_SET    = lfsr_at(HS_SET);
   localparam logic [5:0] HC_HS_CLR    = lfsr_at(HS_CLR);
   localparam logic [5:0] HC_RHB_EARLY = lfsr_at(RHB_EARLY);
   localparam logic [5:0] HC_RHB_LATE  = lfsr_at(RHB_LATE);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [1:0] ph_q,       ph_d;        // clock divider phase
   logic       s1_q,       s1_d;
   logic       s2_q,       s2_d;
   logic [5:0] hcount_q,   hcount_d;
   logic       hsync_q,    hsync_d;
   logic       hblank_q,   hblank_d;
   logic       line_end_q, line_end_d;
   logic       hmove_q,    hmove_d;     // hmove requested during this line
   logic       late_q,     late_d;      // current line uses the late hblank

   logic [5:0] hcount_step;
   logic [5:0] hc_rhb;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one
      // unassigned; a missing default here would infer a latch.
      ph_d        = ph_q + 2'd1;
      s1_d        = (ph_q == 2'd0);
      s2_d        = (ph_q == 2'd2);
      hcount_d    = hcount_q;
      hsync_d     = hsync_q;
      hblank_d    = hblank_q;
      line_end_d  = 1'b0;
      hmove_d     = hmove_q | hmove_req;
      late_d      = late_q;

      hcount_step = lfsr_next(hcount_q);
      hc_rhb      = late_q ? HC_RHB_LATE : HC_RHB_EARLY;

      if (rsync) begin
         // Restart the line. Holding rsync keeps everything frozen here; the
         // hmove flag and the late selection survive the restart.
         ph_d       = 2'd0;
         s1_d       = 1'b0;
         s2_d       = 1'b0;
         hcount_d   = 6'b000000;
         hsync_d    = 1'b0;
         hblank_d   = 1'b1;
         line_end_d = 1'b0;
         hmove_d    = hmove_q;
      end else if (s2_q) begin
         // Advance clock: the registered s2 strobe is high this cycle.
         if (hcount_q == HC_LAST) begin
            // Entering index 0: start a new line. A request arriving on this
            // very clock already applies to the line that starts now.
            hcount_d   = 6'b000000;
            line_end_d = 1'b1;
            hblank_d   = 1'b1;
            late_d     = hmove_q | hmove_req;
            hmove_d    = 1'b0;
         end else begin
            hcount_d = hcount_step;
            if (hcount_step == HC_HS_SET) begin
               hsync_d = 1'b1;
            end
            if (hcount_step == HC_HS_CLR) begin
               hsync_d = 1'b0;
            end
            if (hcount_step == hc_rhb) begin
               hblank_d = 1'b0;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge r) begin
      if (r) begin
         ph_q       <= 2'd0;
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         hcount_q   <= 6'b000000;
         hsync_q    <= 1'b0;
         hblank_q   <= 1'b1;
         line_end_q <= 1'b0;
         hmove_q    <= 1'b0;
         late_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values; blocking here would chain updates within one edge.
         ph_q       <= ph_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         hcount_q   <= hcount_d;
         hsync_q    <= hsync_d;
         hblank_q   <= hblank_d;
         line_end_q <= line_end_d;
         hmove_q    <= hmove_d;
         late_q     <= late_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs (all straight from registers, glitch-free for latch clocking)
   // ---------------------------------------------------------------------------
   assign s1       = s1_q;
   assign s2       = s2_q;
   assign hcount   = hcount_q;
   assign hsync    = hsync_q;
   assign hblank   = hblank_q;
   assign line_end = line_end_q;

endmodule

// File: tb/tb_tia_hsync_counter.sv
// -----------------------------------------------------------------------------
// tb_tia_hsync_counter
//
// Self-checking bench for tia_hsync_counter. The reference model describes a
// line purely in terms of "clocks since the last restart" (n): strobe phase,
// count index k = (n/4) mod 57, and the sync/blank windows follow from k by
// plain arithmetic. Only the hmove flag / late-line bookkeeping is tracked
// clock by clock.
// -----------------------------------------------------------------------------
module tb_tia_hsync_counter;

   localparam int LINE_CLK = 228;

   logic       clk = 1'b0;
   logic       r = 1'b1;
   logic       rsync = 1'b0;
   logic       hmove_req = 1'b0;
   logic       s1, s2, hsync, hblank, line_end;
   logic [5:0] hcount;

   tia_hsync_counter dut (
      .clk       (clk),
      .r         (r),
      .rsync     (rsync),
      .hmove_req (hmove_req),
      .s1        (s1),
      .s2        (s2),
      .hcount    (hcount),
      .hsync     (hsync),
      .hblank    (hblank),
      .line_end  (line_end)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model state
   int         n = 0;          // clocks since reset release / rsync
   bit         flag = 1'b0;    // hmove requested during the current line
   bit         late = 1'b0;    // current line uses the late hblank
   logic [5:0] hc_tab [57];    // counter state for each index k

   // Window statistics
   int le_cnt, hs_cnt, hbl_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h (n=%0d)", tag, obs, exp, n);
      end
   endtask

   task automatic check_model();
      int k;
      k = (n / 4) % 57;
      check("s1",       32'(s1),       32'(n >= 1 && n % 4 == 1));
      check("s2",       32'(s2),       32'(n >= 3 && n % 4 == 3));
      check("hcount",   32'(hcount),   32'(hc_tab[k]));
      check("hsync",    32'(hsync),    32'(k >= 4 && k < 8));
      check("hblank",   32'(hblank),   32'(k < (late ? 18 : 16)));
      check("line_end", 32'(line_end), 32'(n > 0 && n % LINE_CLK == 0));
   endtask

   // One colour clock: inputs are already driven; update the model with what
   // the DUT sampled at this edge, then compare just after the edge.
   task automatic step();
      @(posedge clk);
      if (r) begin
         n = 0; flag = 1'b0; late = 1'b0;
      end else if (rsync) begin
         n = 0;
      end else begin
         n++;
         if (n % LINE_CLK == 0) begin
            late = flag | hmove_req;
            flag = 1'b0;
         end else if (hmove_req) begin
            flag = 1'b1;
         end
      end
      #1;
      check_model();
      if (line_end === 1'b1) le_cnt++;
      if (hsync === 1'b1)    hs_cnt++;
      if (hblank === 1'b0)   hbl_cnt++;
   endtask

   task automatic clear_stats();
      le_cnt = 0; hs_cnt = 0; hbl_cnt = 0;
   endtask

   // Step until n is at the given position in the line (bounded).
   task automatic run_to(input int pos);
      int budget;
      budget = 2 * LINE_CLK;
      while (n % LINE_CLK != pos && budget > 0) begin
         step();
         budget--;
      end
      check("run_to_timeout", 32'(n % LINE_CLK), 32'(pos));
   endtask

   initial begin
      logic [5:0] h;
      int         x;

      h = 6'b000000;
      for (int i = 0; i < 57; i++) begin
         hc_tab[i] = h;
         h = {~(h[1] ^ h[0]), h[5:1]};
      end
      // Spot values of the polynomial sequence
      check("tab_k5", 32'(hc_tab[5]), 32'h3E);
      check("tab_k6", 32'(hc_tab[6]), 32'h1F);

      // Reset held: outputs at reset values
      clear_stats();
      repeat (3) step();

      // Reset release, free run for three full lines
      r = 1'b0;
      clear_stats();
      repeat (3 * LINE_CLK) step();
      check("free_line_end_cnt", 32'(le_cnt),  32'd3);
      check("free_hsync_clks",   32'(hs_cnt),  32'd48);
      check("free_hblank_low",   32'(hbl_cnt), 32'(3 * (LINE_CLK - 64)));

      // hmove mid-line: next line blanks 8 clocks longer, the one after normal
      run_to(100);
      hmove_req = 1'b1; step(); hmove_req = 1'b0;
      run_to(0);
      clear_stats();
      repeat (LINE_CLK) step();
      check("late_hblank_low", 32'(hbl_cnt), 32'(LINE_CLK - 72));
      clear_stats();
      repeat (LINE_CLK) step();
      check("normal_hblank_low", 32'(hbl_cnt), 32'(LINE_CLK - 64));

      // hmove on the wrap clock applies to the line that starts then
      run_to(LINE_CLK - 1);
      hmove_req = 1'b1; step(); hmove_req = 1'b0;
      clear_stats();
      repeat (LINE_CLK) step();
      check("wrap_hmove_low", 32'(hbl_cnt), 32'(LINE_CLK - 72));

      // rsync at k=30 truncates the line; next line_end 228 clocks later
      run_to(120);
      rsync = 1'b1; step(); rsync = 1'b0;
      check("rsync_hcount",   32'(hcount),   32'd0);
      check("rsync_hblank",   32'(hblank),   32'd1);
      check("rsync_line_end", 32'(line_end), 32'd0);
      clear_stats();
      repeat (LINE_CLK) step();
      check("rsync_le_cnt",  32'(le_cnt),   32'd1);
      check("rsync_le_last", 32'(line_end), 32'd1);

      // Randomized hmove / rsync traffic
      for (int i = 0; i < 1500; i++) begin
         x = int'($urandom_range(0, 299));
         rsync     = (x == 0);
         hmove_req = (x >= 1 && x <= 8);
         step();
      end
      rsync = 1'b0;
      hmove_req = 1'b0;

      // Async reset mid-hsync (k=5), with an hmove pending that must be lost
      run_to(10);
      hmove_req = 1'b1; step(); hmove_req = 1'b0;
      run_to(22);
      #3;
      r = 1'b1;
      #1;
      check("async_s1",       32'(s1),       32'd0);
      check("async_s2",       32'(s2),       32'd0);
      check("async_hcount",   32'(hcount),   32'd0);
      check("async_hsync",    32'(hsync),    32'd0);
      check("async_hblank",   32'(hblank),   32'd1);
      check("async_line_end", 32'(line_end), 32'd0);
      n = 0; flag = 1'b0; late = 1'b0;
      repeat (2) step();
      r = 1'b0;
      clear_stats();
      repeat (3 * LINE_CLK) step();
      check("post_rst_le_cnt", 32'(le_cnt),  32'd3);
      check("post_rst_hblank", 32'(hbl_cnt), 32'(3 * (LINE_CLK - 64)));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
